// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter. Accepts a byte over a valid/ready
// handshake and sends start bit, LSB-first data, optional parity and
// stop bit(s) on a registered, idle-high tx line.
module uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  // A 1-cycle bit period still needs a 1-bit counter that simply stays at 0.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // Bit index covers up to DATA_BITS-1 (at most 7) and the stop-bit count.
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          HAS_PAR   = (PARITY_EN != 0);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par;
  logic                 bit_end;

  // Parity of the data word; odd parity inverts the plain XOR reduction.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (^d) ^ PAR_ODD;
  endfunction

  assign bit_end  = (cnt == CNT_LAST);
  assign tx_ready = (state == IDLE);
  assign busy     = ~tx_ready;

  // Frame sequencer: baud counter, bit index, shift register and registered line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      tx_done <= 1'b0;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      par     <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state != IDLE) begin
        cnt <= bit_end ? '0 : cnt + CW'(1);
      end
      case (state)
        IDLE: begin
          if (tx_valid) begin
            shift <= tx_data;
            par   <= parity_of(tx_data);
            cnt   <= '0;
            idx   <= '0;
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            tx    <= shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shift <= shift >> 1;
            if (idx == DATA_LAST) begin
              idx <= '0;
              if (HAS_PAR) begin
                state <= PARITY;
                tx    <= par;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              idx <= idx + BW'(1);
              // shift[1] becomes the new LSB on this edge
              tx  <= shift[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (idx == STOP_LAST) begin
              idx     <= '0;
              state   <= IDLE;
              tx_done <= 1'b1;
            end else begin
              idx <= idx + BW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx across four configurations.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] d0, d1, d2;
  logic [4:0] d3;
  logic       v0, v1, v2, v3;
  logic       tx0, tx1, tx2, tx3;
  logic       rdy0, rdy1, rdy2, rdy3;
  logic       bsy0, bsy1, bsy2, bsy3;
  logic       dn0, dn1, dn2, dn3;

  int n_cmp = 0;
  int n_bad = 0;

  // defaults: 4 clk/bit, 8N1
  uart_tx u0 (.clk(clk), .rst(rst), .tx_data(d0), .tx_valid(v0),
              .tx_ready(rdy0), .tx(tx0), .busy(bsy0), .tx_done(dn0));
  // even parity
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
              .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1),
              .tx_ready(rdy1), .tx(tx1), .busy(bsy1), .tx_done(dn1));
  // odd parity
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
              .clk(clk), .rst(rst), .tx_data(d2), .tx_valid(v2),
              .tx_ready(rdy2), .tx(tx2), .busy(bsy2), .tx_done(dn2));
  // corner config: 1 clk/bit, 5 data bits, 2 stop bits
  uart_tx #(.CLKS_PER_BIT(1), .DATA_BITS(5), .STOP_BITS(2)) u3 (
              .clk(clk), .rst(rst), .tx_data(d3), .tx_valid(v3),
              .tx_ready(rdy3), .tx(tx3), .busy(bsy3), .tx_done(dn3));

  int   sel;
  logic s_tx, s_rdy, s_bsy, s_dn;

  always_comb begin
    s_tx  = 1'b1;
    s_rdy = 1'b0;
    s_bsy = 1'b0;
    s_dn  = 1'b0;
    case (sel)
      0: begin s_tx = tx0; s_rdy = rdy0; s_bsy = bsy0; s_dn = dn0; end
      1: begin s_tx = tx1; s_rdy = rdy1; s_bsy = bsy1; s_dn = dn1; end
      2: begin s_tx = tx2; s_rdy = rdy2; s_bsy = bsy2; s_dn = dn2; end
      3: begin s_tx = tx3; s_rdy = rdy3; s_bsy = bsy3; s_dn = dn3; end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input int id, input logic v, input logic [7:0] data);
    case (id)
      0: begin v0 = v; d0 = data; end
      1: begin v1 = v; d1 = data; end
      2: begin v2 = v; d2 = data; end
      3: begin v3 = v; d3 = data[4:0]; end
      default: ;
    endcase
  endtask

  // Sends one byte and checks every cycle of the frame. bits[i] is the
  // expected line level of frame bit i (start first).
  task automatic run_frame(input int id, input logic [7:0] data, input logic [15:0] bits,
                           input int cpb, input int len, input string nm);
    @(negedge clk);
    sel = id;
    set_in(id, 1'b1, data);
    #1;
    chk($sformatf("%s ready_before", nm), 16'(s_rdy), 16'h1);
    @(posedge clk);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (k == 0) set_in(id, 1'b0, 8'h00);
      #1;
      chk($sformatf("%s tx[%0d]", nm, k), 16'(s_tx), 16'(bits[k / cpb]));
      chk($sformatf("%s rdy/busy/done[%0d]", nm, k), 16'({s_rdy, s_bsy, s_dn}), 16'b010);
    end
    @(negedge clk);
    #1;
    chk($sformatf("%s end tx", nm), 16'(s_tx), 16'h1);
    chk($sformatf("%s end rdy/busy/done", nm), 16'({s_rdy, s_bsy, s_dn}), 16'b101);
    @(negedge clk);
    #1;
    chk($sformatf("%s done_cleared", nm), 16'(s_dn), 16'h0);
  endtask

  typedef struct {
    int          id;
    logic [7:0]  data;
    logic [15:0] bits;
    int          cpb;
    int          len;
    string       name;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int done_cnt;
    int done_at[2];
    logic [15:0] f1, f2;

    // start, LSB-first data, [parity], stop(s); bit 0 of each constant = start
    tbl[0] = '{0, 8'hA5, 16'h034A, 4, 40, "8N1_A5"};
    tbl[1] = '{1, 8'hA5, 16'h054A, 4, 44, "even_A5"};
    tbl[2] = '{2, 8'hA5, 16'h074A, 4, 44, "odd_A5"};
    tbl[3] = '{1, 8'h01, 16'h0602, 4, 44, "even_01"};
    tbl[4] = '{3, 8'hF3, 16'h00E6, 1,  8, "5N2_cpb1_13"};
    tbl[5] = '{3, 8'h13, 16'h00E6, 1,  8, "5N2_cpb1_13b"};

    rst = 1'b0;
    sel = 0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;

    // Reset and idle
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", {tx0, rdy0, bsy0, dn0, tx1, rdy1, bsy1, dn1,
                         tx2, rdy2, bsy2, dn2, tx3, rdy3, bsy3, dn3}, 16'hCCCC);
    end
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("idle", {tx0, rdy0, bsy0, dn0, tx1, rdy1, bsy1, dn1,
                   tx2, rdy2, bsy2, dn2, tx3, rdy3, bsy3, dn3}, 16'hCCCC);
    end

    // Table-driven single frames
    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].id, tbl[i].data, tbl[i].bits, tbl[i].cpb, tbl[i].len, tbl[i].name);
    end

    // Back-to-back 0x55 then 0x0F with tx_valid held high
    f1 = 16'h02AA;
    f2 = 16'h021E;
    done_cnt = 0;
    done_at[0] = -1;
    done_at[1] = -1;
    @(negedge clk);
    sel = 0;
    v0 = 1'b1;
    d0 = 8'h55;
    @(posedge clk);
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      if (k == 0) d0 = 8'h0F;
      if (k == 41) v0 = 1'b0;
      #1;
      if (dn0) begin
        if (done_cnt < 2) done_at[done_cnt] = k;
        done_cnt++;
      end
      if (k < 40)
        chk($sformatf("b2b f1 tx[%0d]", k), 16'(tx0), 16'(f1[k / 4]));
      else if (k == 40)
        chk("b2b idle gap tx", 16'(tx0), 16'h1);
      else if (k < 81)
        chk($sformatf("b2b f2 tx[%0d]", k - 41), 16'(tx0), 16'(f2[(k - 41) / 4]));
      else
        chk($sformatf("b2b after tx[%0d]", k), 16'(tx0), 16'h1);
    end
    chk("b2b done_count", 16'(done_cnt), 16'd2);
    chk("b2b done1_at", 16'(done_at[0]), 16'd40);
    chk("b2b done2_at", 16'(done_at[1]), 16'd81);

    // Reset during the 3rd data bit of 0xFF
    @(negedge clk);
    sel = 0;
    v0 = 1'b1;
    d0 = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    repeat (13) @(negedge clk);
    #1;
    chk("midrst tx_before", 16'({tx0, rdy0}), 16'b10);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst after_edge", 16'({tx0, rdy0, bsy0, dn0}), 16'b1100);
    rst = 1'b1;
    repeat (30) begin
      @(negedge clk);
      #1;
      chk("midrst quiet", 16'({tx0, rdy0, dn0}), 16'b110);
    end
    run_frame(0, 8'h3C, 16'h0278, 4, 40, "post_rst_3C");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
